icache_assoc: RTL and testbench
===============================

# icache_assoc

- Parametrised, N-way set-associative, read-only instruction cache for the fetch path.
- Sits between the fetch unit and higher memory, as the next generation of the direct-mapped icache.
- Adds configurable associativity, per-set round-robin replacement, a whole-cache flush (fence.i) and burst line fills.
- Controller and datapath are merged into one FSM-driven block.

## Interface
- LINE_SIZE, 32: bytes per line; power of two, at least XLEN/8.
- CACHE_SIZE, 1024: total data bytes; power of two.
- XLEN, 32: address and data width in bits.
- WAYS, 2: associativity; power of two, 1–8. WAYS=1 gives direct-mapped.
- clk  in  1  single clock; all logic on the rising edge.
- rst_if  reset_if  —  rst_if.reset is synchronous, active-high.
- req_valid  in  1  fetch request.
- req_addr  in  XLEN  byte address; bits [1:0] are ignored.
- req_ready  out  1  request accepted when req_valid && req_ready.
- rsp_valid  out  1  one-cycle pulse carrying rsp_data; no backpressure.
- rsp_data  out  XLEN  instruction word.
- flush  in  1  invalidate every line.
- hmem_req_valid  out  1  line fill request.
- hmem_req_addr  out  XLEN  line-aligned byte address.
- hmem_req_ready  in  1  fill request accepted.
- hmem_rsp_valid  in  1  fill beat valid.
- hmem_rsp_data  in  XLEN  fill beat, in ascending word order.
- hit_count, miss_count  out  32 each  present only under ICACHE_PERF_COUNTERS_EN.

## Operation
Derived constants:
- WPL = LINE_SIZE/(XLEN/8)
- SETS = CACHE_SIZE/(LINE_SIZE*WAYS)
- Address split: offset = log2(LINE_SIZE) bits, index = log2(SETS) bits, tag = the remaining bits.

States and transitions:
- IDLE: req_ready = !flush && !flush_pend.
  - flush high: go to FLUSH.
  - Accepted request: latch the address, go to LOOKUP.
- LOOKUP: compare the tag against all ways of the set.
  - Hit: rsp_valid=1, rsp_data = the selected word, go to IDLE.
  - Miss: choose a victim, go to FILL_REQ.
- Victim choice: lowest-index invalid way; if all ways are valid, the set's round-robin pointer. The pointer increments modulo WAYS on every fill into that set.
- FILL_REQ: hold hmem_req_valid and hmem_req_addr stable until hmem_req_ready, then clear the victim's valid bit, load the beat counter to WPL-1 and go to FILL.
- FILL: each hmem_rsp_valid writes one word and decrements the counter. The beat written at counter 0 writes the tag, sets valid and goes to LOOKUP. The replayed lookup hits.
- FLUSH: lasts one cycle. Clears all valid bits and round-robin pointers, clears flush_pend, goes to IDLE.

Boundary conditions:
- flush and req_valid in the same IDLE cycle: flush wins; the request is not accepted.
- flush outside IDLE: sets flush_pend. The in-flight request completes and responds first; FLUSH follows.
- hmem_rsp_valid outside FILL: ignored.
- Reset, including mid-fill: all valid bits, pointers, counters, flush_pend and state are cleared (state = IDLE). Data and tag arrays are not reset.

## Timing
- Reset values: req_ready=1 (once reset deasserts), rsp_valid=0, rsp_data=0, hmem_req_valid=0, hmem_req_addr=0, counters=0.
- Hit: request accepted in cycle N; rsp_valid in cycle N+1.
- Miss: hmem_req_valid rises in N+2. With the final fill beat in cycle F, rsp_valid occurs in F+1 (replay LOOKUP). req_ready goes high again in F+2.
- Flush in IDLE at cycle N: req_ready=0 in N and N+1; a request accepted in N+2 sees a cold cache.
- One outstanding request only; rsp_data is held until the next response.

## Configuration
- ICACHE_PERF_COUNTERS_EN defined:
  - hit_count increments once per LOOKUP hit that is not a replay.
  - miss_count increments once per miss.
  - Both wrap at 2^32 and are cleared by reset but not by flush.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- torrence_types gains:
  - icache_state_e: IDLE, LOOKUP, FILL_REQ, FILL, FLUSH.
  - Helper functions for the derived constants: WPL, SETS, offset/index/tag widths.
- One sub-module, icache_way: tag, valid and data storage for a single way, with a write port and a combinational read by index/word. It is instantiated WAYS times from a generate loop.
- Tag compare, victim select, round-robin pointers and the FSM live in icache_assoc.

## Test plan
- Cold miss at 0x0000_0100 with hmem returning 0x1000+k for beat k: one hmem request at 0x100, 8 beats, then rsp_data=0x1000, rsp_valid exactly one cycle after beat 7.
- Hit: request 0x0000_0104 afterwards → rsp_data=0x1001 one cycle after acceptance, no hmem activity.
- Conflict (defaults, set 0): fetch 0x000, 0x200, then 0x400 → 0x400 evicts way 0. Then 0x200 hits and 0x000 misses.
- Flush asserted together with req_valid: the request is not accepted and all lines are invalid. The re-presented 0x104 misses and refetches.
- Reset during FILL beat 3: state returns to IDLE, late hmem beats are ignored, and the next 0x100 fetch misses.
- Under ICACHE_PERF_COUNTERS_EN, the sequence miss, hit, hit, miss → hit_count=2, miss_count=2.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared types and derived-geometry helpers for the set-associative instruction cache.
package icache_assoc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL,
        FLUSH
    } icache_state_e;

    function automatic int calc_wpl(int line_size, int xlen);
        return line_size / (xlen / 8);
    endfunction

    function automatic int calc_sets(int cache_size, int line_size, int ways);
        return cache_size / (line_size * ways);
    endfunction

    function automatic int calc_off_w(int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int calc_idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(int xlen, int line_size, int sets);
        return xlen - $clog2(line_size) - $clog2(sets);
    endfunction

    // Zero-width fields (one set, one way, one word) still need a 1-bit vector.
    function automatic int min1(int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Reset and fetch/fill bus interfaces for icache_assoc; master is the fetch unit plus memory side.
interface reset_if;
    logic reset;

    modport master (output reset);
    modport slave  (input  reset);
endinterface

interface icache_assoc_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            flush;
    logic            hmem_req_valid;
    logic [XLEN-1:0] hmem_req_addr;
    logic            hmem_req_ready;
    logic            hmem_rsp_valid;
    logic [XLEN-1:0] hmem_rsp_data;

    modport master (
        output req_valid, req_addr, flush, hmem_req_ready, hmem_rsp_valid, hmem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, hmem_req_valid, hmem_req_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, hmem_req_ready, hmem_rsp_valid, hmem_rsp_data,
        output req_ready, rsp_valid, rsp_data, hmem_req_valid, hmem_req_addr
    );
endinterface

// File: rtl/icache_assoc_way.sv
// One way of the cache: tag, valid and data storage with a write port and combinational read.
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WPL   = 8,
    parameter int TAG_W = 23,
    parameter int IDX_W = 4,
    parameter int WRD_W = 3,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic             clr_en,
    input  logic             data_we,
    input  logic             tag_we,
    input  logic [IDX_W-1:0] index,
    input  logic [WRD_W-1:0] wr_word,
    input  logic [WRD_W-1:0] rd_word,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_data
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [XLEN-1:0]  data_mem [SETS][WPL];

    // Only the valid bits are reset; stale tags and data are harmless while invalid.
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            valid <= '0;
        end else begin
            if (clr_en) valid[index] <= 1'b0;
            if (tag_we) valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tag_mem[index]           <= wr_tag;
        if (data_we) data_mem[index][wr_word] <= wr_data;
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[index][rd_word];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with round-robin replacement and burst fills.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int WAYS       = 2
) (
    input  logic          clk,
    reset_if.slave        rst_if,
    icache_assoc_if.slave bus
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int WPL      = calc_wpl(LINE_SIZE, XLEN);
    localparam int SETS     = calc_sets(CACHE_SIZE, LINE_SIZE, WAYS);
    localparam int OFF_W    = calc_off_w(LINE_SIZE);
    localparam int IDX_BITS = calc_idx_w(SETS);
    localparam int IDX_W    = min1(IDX_BITS);
    localparam int TAG_W    = calc_tag_w(XLEN, LINE_SIZE, SETS);
    localparam int WRD_W    = min1($clog2(WPL));
    localparam int WAY_W    = min1($clog2(WAYS));
    localparam int BYTE_W   = $clog2(XLEN / 8);

    logic rst;
    assign rst = rst_if.reset;

    icache_state_e    state, state_n;
    logic [XLEN-1:0]  addr_q;
    logic [WAY_W-1:0] victim_q;
    logic [WRD_W-1:0] beat_cnt;
    logic             replay_q;
    logic             flush_pend;
    logic [XLEN-1:0]  rsp_data_q;
    logic [WAY_W-1:0] rr_ptr [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [WRD_W-1:0] word;
    logic [WRD_W-1:0] fill_word;

    assign idx       = IDX_W'((addr_q >> OFF_W) & XLEN'(SETS - 1));
    assign tag       = TAG_W'(addr_q >> (OFF_W + IDX_BITS));
    assign word      = WRD_W'((addr_q >> BYTE_W) & XLEN'(WPL - 1));
    assign fill_word = WRD_W'(WPL - 1) - beat_cnt;

    logic             way_valid [WAYS];
    logic [TAG_W-1:0] way_tag   [WAYS];
    logic [XLEN-1:0]  way_data  [WAYS];

    logic req_ready, rsp_valid, hmem_req_valid;
    logic accept, fill_start, fill_beat, fill_last, do_flush;
    logic hit;
    logic [XLEN-1:0]  hit_data;
    logic [WAY_W-1:0] victim;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel = (victim_q == WAY_W'(w));

        icache_way #(
            .SETS  (SETS),
            .WPL   (WPL),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W),
            .WRD_W (WRD_W),
            .XLEN  (XLEN)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .clr_all  (do_flush),
            .clr_en   (fill_start && sel),
            .data_we  (fill_beat && sel),
            .tag_we   (fill_last && sel),
            .index    (idx),
            .wr_word  (fill_word),
            .rd_word  (word),
            .wr_data  (bus.hmem_rsp_data),
            .wr_tag   (tag),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == tag)) begin
                hit      = 1'b1;
                hit_data = way_data[w];
            end
        end
    end

    // Descending scan so the lowest-index invalid way ends up chosen.
    always_comb begin
        victim = rr_ptr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n        = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        hmem_req_valid = 1'b0;
        accept         = 1'b0;
        fill_start     = 1'b0;
        fill_beat      = 1'b0;
        fill_last      = 1'b0;
        do_flush       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !bus.flush && !flush_pend;
                if (bus.flush || flush_pend) begin
                    state_n = FLUSH;
                end else if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_n = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_valid = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n   = FILL_REQ;
                end
            end
            FILL_REQ: begin
                hmem_req_valid = 1'b1;
                if (bus.hmem_req_ready) begin
                    fill_start = 1'b1;
                    state_n    = FILL;
                end
            end
            FILL: begin
                if (bus.hmem_rsp_valid) begin
                    fill_beat = 1'b1;
                    if (beat_cnt == '0) begin
                        fill_last = 1'b1;
                        state_n   = LOOKUP;
                    end
                end
            end
            FLUSH: begin
                do_flush = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            victim_q   <= '0;
            beat_cnt   <= '0;
            replay_q   <= 1'b0;
            flush_pend <= 1'b0;
            rsp_data_q <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            if (accept) begin
                addr_q   <= bus.req_addr;
                replay_q <= 1'b0;
            end
            if (state == LOOKUP && !hit) victim_q <= victim;
            if (fill_start) begin
                beat_cnt    <= WRD_W'(WPL - 1);
                rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;
            end
            if (fill_beat && !fill_last) beat_cnt <= beat_cnt - 1'b1;
            if (fill_last) replay_q <= 1'b1;
            if (rsp_valid) rsp_data_q <= hit_data;
            if (do_flush) begin
                flush_pend <= 1'b0;
                for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
            end else if (bus.flush && state != IDLE) begin
                flush_pend <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    // Replayed lookups after a fill are not counted as hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit && !replay_q) hit_count  <= hit_count + 32'd1;
            if (!hit)             miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign bus.req_ready      = req_ready;
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_data       = rsp_valid ? hit_data : rsp_data_q;
    assign bus.hmem_req_valid = hmem_req_valid;
    assign bus.hmem_req_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_assoc.sv
// Directed testbench for icache_assoc with default geometry (32B lines, 1KB, 2 ways, 16 sets).
module tb_icache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    reset_if rif ();
    icache_assoc_if #(.XLEN(32)) bus ();

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_assoc #(
        .LINE_SIZE  (32),
        .CACHE_SIZE (1024),
        .XLEN       (32),
        .WAYS       (2)
    ) dut (
        .clk        (clk),
        .rst_if     (rif),
        .bus        (bus)
`ifdef ICACHE_PERF_COUNTERS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    int          hmem_reqs     = 0;
    logic [31:0] last_req_addr = '0;
    int          req_seen_cyc  = -1;
    int          last_beat_cyc = -1;
    int          cur_beat      = -1;
    bit          resp_busy     = 1'b0;
    int          rsp_cnt       = 0;

    // Backing memory: word k of line L is (L<<4)+k; line 0 gets a marker so it never reads as zero.
    function automatic logic [31:0] mem_word(logic [31:0] line, int k);
        logic [31:0] v;
        v = (line << 4) + 32'(k);
        if (line == 32'h0) v = v + 32'h00AB_0000;
        return v;
    endfunction

    always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

    initial begin
        bus.hmem_req_ready = 1'b1;
        bus.hmem_rsp_valid = 1'b0;
        bus.hmem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.hmem_req_valid && bus.hmem_req_ready) begin
                hmem_reqs++;
                last_req_addr = bus.hmem_req_addr;
                req_seen_cyc  = cyc;
                resp_busy     = 1'b1;
                @(posedge clk);
                #1;
                for (int k = 0; k < 8; k++) begin
                    bus.hmem_rsp_valid = 1'b1;
                    bus.hmem_rsp_data  = mem_word(last_req_addr, k);
                    cur_beat           = k;
                    last_beat_cyc      = cyc;
                    @(posedge clk);
                    #1;
                end
                bus.hmem_rsp_valid = 1'b0;
                cur_beat           = -1;
                resp_busy          = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output logic [31:0] data,
                         output int acc_cyc, output int rsp_cyc, output bit ok);
        ok = 1'b0; data = '0; acc_cyc = -1; rsp_cyc = -1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (acc_cyc >= 0) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin
                    data    = bus.rsp_data;
                    rsp_cyc = cyc;
                    ok      = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rif.reset     = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rif.reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        checks++; if (bus.hmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_hmem_req_valid got %0b want 0", bus.hmem_req_valid); end
        checks++; if (bus.hmem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_hmem_req_addr got %h want 0", bus.hmem_req_addr); end
`ifdef ICACHE_PERF_COUNTERS_EN
        checks++; if (hit_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_hit_count got %0d want 0", hit_count); end
        checks++; if (miss_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_miss_count got %0d want 0", miss_count); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; int acc, rsp, r0; bit ok;
        r0 = hmem_reqs;
        fetch(32'h0000_0100, d, acc, rsp, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL cold_rsp_timeout got none want response"); end
        checks++; if (hmem_reqs !== r0 + 1) begin errors++; $display("[TB] FAIL cold_hmem_reqs got %0d want %0d", hmem_reqs - r0, 1); end
        checks++; if (last_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL cold_hmem_addr got %h want 00000100", last_req_addr); end
        checks++; if (req_seen_cyc !== acc + 2) begin errors++; $display("[TB] FAIL cold_hmem_req_cycle got %0d want %0d", req_seen_cyc, acc + 2); end
        checks++; if (d !== 32'h1000) begin errors++; $display("[TB] FAIL cold_rsp_data got %h want 00001000", d); end
        checks++; if (rsp !== last_beat_cyc + 1) begin errors++; $display("[TB] FAIL cold_rsp_cycle got %0d want %0d", rsp, last_beat_cyc + 1); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL cold_rsp_pulse got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL cold_ready_after got %0b want 1", bus.req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hit();
        logic [31:0] d; int acc, rsp, r0; bit ok;
        r0 = hmem_reqs;
        fetch(32'h0000_0104, d, acc, rsp, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL hit_rsp_timeout got none want response"); end
        checks++; if (d !== 32'h1001) begin errors++; $display("[TB] FAIL hit_rsp_data got %h want 00001001", d); end
        checks++; if (rsp !== acc + 1) begin errors++; $display("[TB] FAIL hit_latency got %0d want %0d", rsp - acc, 1); end
        checks++; if (hmem_reqs !== r0) begin errors++; $display("[TB] FAIL hit_hmem_reqs got %0d want 0", hmem_reqs - r0); end
        @(negedge clk);
        checks++; if (bus.rsp_data !== 32'h1001) begin errors++; $display("[TB] FAIL hit_rsp_hold got %h want 00001001", bus.rsp_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_conflict();
        logic [31:0] d; int acc, rsp, r0; bit ok;
        r0 = hmem_reqs;
        fetch(32'h0000_0000, d, acc, rsp, ok);
        checks++; if (d !== 32'h00AB_0000) begin errors++; $display("[TB] FAIL conf_000_data got %h want 00ab0000", d); end
        fetch(32'h0000_0200, d, acc, rsp, ok);
        checks++; if (d !== 32'h2000) begin errors++; $display("[TB] FAIL conf_200_data got %h want 00002000", d); end
        fetch(32'h0000_0400, d, acc, rsp, ok);
        checks++; if (d !== 32'h4000) begin errors++; $display("[TB] FAIL conf_400_data got %h want 00004000", d); end
        checks++; if (hmem_reqs !== r0 + 3) begin errors++; $display("[TB] FAIL conf_fills got %0d want 3", hmem_reqs - r0); end
        fetch(32'h0000_0200, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 3) begin errors++; $display("[TB] FAIL conf_200_hit got %0d fills want 3", hmem_reqs - r0); end
        checks++; if (d !== 32'h2000 || rsp !== acc + 1) begin errors++; $display("[TB] FAIL conf_200_rsp got %h lat %0d want 00002000 lat 1", d, rsp - acc); end
        fetch(32'h0000_0000, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 4) begin errors++; $display("[TB] FAIL conf_000_miss got %0d fills want 4", hmem_reqs - r0); end
        checks++; if (d !== 32'h00AB_0000) begin errors++; $display("[TB] FAIL conf_000_refill got %h want 00ab0000", d); end
    endtask

    task automatic test_flush();
        logic [31:0] d; int acc, rsp, r0, c0; bit ok;
        r0 = hmem_reqs;
        c0 = rsp_cnt;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0104;
        bus.flush     = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready_n got %0b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready_n1 got %0b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_n2 got %0b want 1", bus.req_ready); end
        checks++; if (rsp_cnt !== c0) begin errors++; $display("[TB] FAIL flush_no_rsp got %0d want 0", rsp_cnt - c0); end
        @(posedge clk);
        #1;
        fetch(32'h0000_0104, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 1 || last_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL flush_refetch got %0d fills addr %h want 1 addr 00000100", hmem_reqs - r0, last_req_addr); end
        checks++; if (d !== 32'h1001) begin errors++; $display("[TB] FAIL flush_refetch_data got %h want 00001001", d); end
        fetch(32'h0000_0400, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 2) begin errors++; $display("[TB] FAIL flush_400_miss got %0d fills want 2", hmem_reqs - r0); end
    endtask

    task automatic test_flush_pending();
        logic [31:0] d; int acc, rsp, r0; bit ok;
        r0 = hmem_reqs;
        fork
            fetch(32'h0000_0500, d, acc, rsp, ok);
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
            end
        join
        checks++; if (!ok || d !== 32'h5000) begin errors++; $display("[TB] FAIL pend_rsp got ok=%0b %h want ok=1 00005000", ok, d); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ready_idle got %0b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ready_flush got %0b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        fetch(32'h0000_0104, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 2 || d !== 32'h1001) begin errors++; $display("[TB] FAIL pend_cold got %0d fills %h want 2 00001001", hmem_reqs - r0, d); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d; int acc, rsp, r0, c0; bit ok, seen;
        r0 = hmem_reqs;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0700;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cur_beat == 3) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rmf_beat3_timeout got none want beat 3"); end
        c0 = rsp_cnt;
        rif.reset = 1'b1;
        @(posedge clk);
        #1;
        rif.reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.hmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmf_idle got ready=%0b hreq=%0b want 1 0", bus.req_ready, bus.hmem_req_valid); end
        for (int i = 0; i < 20 && resp_busy; i++) @(negedge clk);
        checks++; if (rsp_cnt !== c0) begin errors++; $display("[TB] FAIL rmf_late_beats got %0d rsp want 0", rsp_cnt - c0); end
        @(posedge clk);
        #1;
        fetch(32'h0000_0100, d, acc, rsp, ok);
        checks++; if (hmem_reqs !== r0 + 2 || d !== 32'h1000) begin errors++; $display("[TB] FAIL rmf_refetch got %0d fills %h want 2 00001000", hmem_reqs - r0, d); end
    endtask

`ifdef ICACHE_PERF_COUNTERS_EN
    task automatic test_perf_counters();
        logic [31:0] d; int acc, rsp; bit ok;
        rif.reset = 1'b1;
        @(posedge clk);
        #1;
        rif.reset = 1'b0;
        fetch(32'h0000_0100, d, acc, rsp, ok);
        fetch(32'h0000_0104, d, acc, rsp, ok);
        fetch(32'h0000_0108, d, acc, rsp, ok);
        checks++; if (d !== 32'h1002) begin errors++; $display("[TB] FAIL perf_108_data got %h want 00001002", d); end
        fetch(32'h0000_0300, d, acc, rsp, ok);
        @(negedge clk);
        checks++; if (hit_count !== 32'd2) begin errors++; $display("[TB] FAIL perf_hit_count got %0d want 2", hit_count); end
        checks++; if (miss_count !== 32'd2) begin errors++; $display("[TB] FAIL perf_miss_count got %0d want 2", miss_count); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        $display("[TB] starting icache_assoc bench");
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_flush_pending();
        test_reset_mid_fill();
`ifdef ICACHE_PERF_COUNTERS_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
